// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-level FSM encoding,
// data width and the bit-recovery majority vote.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } uart_state_e;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart8_receiver_if.sv
// Receive-side bundle between the RX pin logic
// and the command decoder.
interface uart8_receiver_if;
  logic       en;
  logic       in;
  logic [7:0] out;
  logic       done;
  logic       busy;
  logic       err;

  modport master (
    output en,
    output in,
    input  out,
    input  done,
    input  busy,
    input  err
  );

  modport slave (
    input  en,
    input  in,
    output out,
    output done,
    output busy,
    output err
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous pins;
// resets to the idle-high line level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart8_receiver.sv
// 8N1 UART receiver, oversampled, with a 3-sample
// majority vote centred on mid-bit.
module uart8_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input logic              clk,
  input logic              rst_n,
  uart8_receiver_if.slave  rx
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_S0   = CW'(OVERSAMPLE - 3);
  localparam logic [CW-1:0] C_S1   = CW'(OVERSAMPLE - 2);
  localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    I_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e   state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic [1:0]    smp;
  logic          rx_s;
  logic          bit_v;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx.in),
    .q     (rx_s)
  );

  // third vote is the live sample at the decision edge
  assign bit_v = maj3(smp[0], smp[1], rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      smp     <= '0;
      rx.out  <= '0;
      rx.done <= 1'b0;
      rx.err  <= 1'b0;
      rx.busy <= 1'b0;
    end else begin
      rx.done <= 1'b0;
      rx.err  <= 1'b0;
      if (cnt == C_S0) smp[0] <= rx_s;
      if (cnt == C_S1) smp[1] <= rx_s;
      case (state)
        IDLE: begin
          if (rx.en && !rx_s) begin
            cnt     <= '0;
            state   <= START;
            rx.busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == C_HALF) begin
            if (rx_s) begin
              state   <= IDLE;
              rx.busy <= 1'b0;
            end else begin
              cnt   <= '0;
              idx   <= '0;
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == C_LAST) begin
            cnt <= '0;
            sh  <= {bit_v, sh[7:1]};
            idx <= idx + 3'd1;
            if (idx == I_LAST) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == C_LAST) begin
            cnt <= '0;
            if (bit_v) begin
              rx.out  <= sh;
              rx.done <= 1'b1;
              rx.busy <= 1'b0;
              state   <= IDLE;
            end else begin
              rx.err <= 1'b1;
              state  <= RECOVER;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RECOVER: begin
          if (rx_s) begin
            state   <= IDLE;
            rx.busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          rx.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart8_receiver.sv
// Randomized scoreboard bench for uart8_receiver
// against a frame-level reference model.
module tb_uart8_receiver;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  uart8_receiver_if rx_if ();

  uart8_receiver #(.OVERSAMPLE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  int checks = 0;
  int errors = 0;
  int dcnt = 0;
  int ecnt = 0;
  int busy_cyc = 0;
  int low_run = 0;
  int gap_len = 0;
  int done_cyc = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.is_err = !stop;
    e.data   = stop ? d : last_good;
    if (stop) last_good = d;
    exp_q.push_back(e);
  endtask

  // line model: bit k of {stop,d,start} occupies cycles
  // [k*p/100, (k+1)*p/100); p is the bit period in centi-cycles
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int p, input bit glitch,
                            input int abort_at, output int t0);
    logic [9:0] fr;
    logic       v;
    int         len;
    int         k;
    fr  = {stop, d, 1'b0};
    len = (10 * p) / 100;
    t0  = 0;
    for (int n = 0; n < len; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) t0 = cyc;
      if (n == abort_at) begin
        rst_n    = 1'b0;
        rx_if.in = 1'b1;
        return;
      end
      k = (n * 100) / p;
      v = fr[k];
      if (glitch && n >= 16 && (n % 16) == 7) v = ~v;
      rx_if.in = v;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rx_if.in = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_if.busy) busy_cyc++;
      if (!rx_if.busy) low_run++;
      if (rx_if.busy && !prev_busy) gap_len = low_run;
      if (rx_if.busy) low_run = 0;
      prev_busy = rx_if.busy;
      if (rx_if.done) begin
        dcnt++;
        done_cyc = cyc;
      end
      if (rx_if.err) ecnt++;
      if (rx_if.done || rx_if.err) begin
        chk("sb_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_kind", {rx_if.done, rx_if.err},
              e.is_err ? 2'b01 : 2'b10);
          chk("sb_out", rx_if.out, e.data);
        end
      end
    end else begin
      prev_busy = 1'b0;
      low_run   = 0;
    end
  end

  initial begin
    int t0;
    int d0, e0, b0;
    int p;
    bit g;
    logic [7:0] d;
    logic st;

    rst_n    = 1'b0;
    rx_if.en = 1'b1;
    rx_if.in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", rx_if.out, 8'h00);
    chk("rst_done", rx_if.done, 1'b0);
    chk("rst_err", rx_if.err, 1'b0);
    chk("rst_busy", rx_if.busy, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // nominal frame: 2 sync + 1 detect + 152 to the stop decision
    d0 = dcnt; e0 = ecnt;
    expect_frame(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1, 1600, 1'b0, -1, t0);
    idle(4);
    chk("a5_latency", done_cyc - t0, 155);
    chk("a5_done_cnt", dcnt - d0, 1);
    chk("a5_err_cnt", ecnt - e0, 0);
    chk("a5_out", rx_if.out, 8'hA5);

    // back to back: busy idles through the late stop bit only
    d0 = dcnt;
    expect_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1, 1600, 1'b0, -1, t0);
    expect_frame(8'hFF, 1'b1);
    send_frame(8'hFF, 1'b1, 1600, 1'b0, -1, t0);
    idle(4);
    chk("b2b_done_cnt", dcnt - d0, 2);
    chk("b2b_gap", (gap_len >= 1) && (gap_len <= 9), 1'b1);
    chk("b2b_out", rx_if.out, 8'hFF);

    // short low glitch in idle
    d0 = dcnt; e0 = ecnt; b0 = busy_cyc;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      rx_if.in = (n < 5) ? 1'b0 : 1'b1;
    end
    chk("glitch_busy",
        (busy_cyc - b0 > 0) && (busy_cyc - b0 <= 9), 1'b1);
    chk("glitch_pulses", (dcnt - d0) + (ecnt - e0), 0);

    // framing error with a held-low line
    e0 = ecnt;
    expect_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0, 1600, 1'b0, -1, t0);
    repeat (24) @(posedge clk);
    #1;
    chk("ferr_busy_held", rx_if.busy, 1'b1);
    chk("ferr_err_cnt", ecnt - e0, 1);
    chk("ferr_out_kept", rx_if.out, 8'hFF);
    idle(5);
    chk("ferr_busy_rel", rx_if.busy, 1'b0);

    // majority vote and baud tolerance
    expect_frame(8'h5A, 1'b1);
    send_frame(8'h5A, 1'b1, 1600, 1'b1, -1, t0);
    idle(3);
    chk("maj_out", rx_if.out, 8'h5A);
    expect_frame(8'h81, 1'b1);
    send_frame(8'h81, 1'b1, 1553, 1'b0, -1, t0);
    idle(3);
    chk("fast_out", rx_if.out, 8'h81);

    // disabled receiver ignores a frame
    d0 = dcnt; b0 = busy_cyc;
    rx_if.en = 1'b0;
    send_frame(8'h77, 1'b1, 1600, 1'b0, -1, t0);
    idle(4);
    chk("en0_busy", busy_cyc - b0, 0);
    chk("en0_done", dcnt - d0, 0);
    rx_if.en = 1'b1;

    // reset during data bit 4
    send_frame(8'hC3, 1'b1, 1600, 1'b0, 88, t0);
    #1;
    chk("abort_out", rx_if.out, 8'h00);
    chk("abort_busy", rx_if.busy, 1'b0);
    chk("abort_pulse", {rx_if.done, rx_if.err}, 2'b00);
    last_good = 8'h00;
    idle(3);
    rst_n = 1'b1;
    idle(3);
    expect_frame(8'h42, 1'b1);
    send_frame(8'h42, 1'b1, 1600, 1'b0, -1, t0);
    idle(3);
    chk("post_rst_out", rx_if.out, 8'h42);

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 2))
        0: p = 1600;
        1: p = 1553;
        default: p = 1648;
      endcase
      g = (p == 1600) && ($urandom_range(0, 1) == 1);
      expect_frame(d, st);
      send_frame(d, st, p, g, -1, t0);
      idle(st ? $urandom_range(0, 12) : $urandom_range(4, 12));
    end

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++)
      @(posedge clk);
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
